// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core's HI/LO multiply/divide unit.
package mips_pkg;

   localparam int unsigned MULDIV_STEPS = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_NOP6  = 3'b110,
      OP_NOP7  = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div loop: add for shift-add multiply,
// trial subtract with restore for restoring divide.
module muldiv_step #(
   parameter int unsigned W = 33
) (
   input  logic         mode,
   input  logic [W-1:0] partial,
   input  logic [W-1:0] operand,
   output logic [W-1:0] next_c,
   output logic         q_bit_c
);

   logic [W:0] diff;
   logic [W-1:0] sum;

   always_comb begin
      diff    = {1'b0, partial} - {1'b0, operand};
      sum     = partial + operand;
      next_c  = sum;
      q_bit_c = 1'b0;
      if (mode) begin
         // No borrow means the divisor fit: keep the difference, emit a 1.
         q_bit_c = ~diff[W];
         next_c  = diff[W] ? partial : diff[W-1:0];
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one step per cycle,
// sign fix-up and HI/LO write in a final FIX cycle.
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int unsigned PW = XLEN + 1;
   localparam int unsigned CW = 6;
   localparam int unsigned DW = 2 * XLEN;

   muldiv_state_t   state_q, state_d;
   muldiv_op_t      op_c;
   logic [CW-1:0]   cnt_q;
   logic [PW-1:0]   acc_q;
   logic [XLEN-1:0] mq_q;
   logic [XLEN-1:0] mcand_q;
   logic            is_div_q, neg_lo_q, neg_hi_q, div_zero_q;

   logic            load_c, run_c, fix_c, mthi_c, mtlo_c;
   logic            is_signed_c, sa_c, sb_c;
   logic [XLEN-1:0] mag_a_c, mag_b_c;
   logic [PW-1:0]   step_partial_c, step_operand_c, step_next_c;
   logic            step_q_bit_c;
   logic [DW-1:0]   prod_c, prod_fix_c;
   logic [XLEN-1:0] quot_fix_c, rem_fix_c;

   assign op_c = muldiv_op_t'(op);

   // Next-state and datapath enables.
   always_comb begin
      state_d = state_q;
      load_c  = 1'b0;
      run_c   = 1'b0;
      fix_c   = 1'b0;
      mthi_c  = 1'b0;
      mtlo_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               case (op_c)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     load_c  = 1'b1;
                     state_d = ST_RUN;
                  end
                  OP_MTHI: mthi_c = 1'b1;
                  OP_MTLO: mtlo_c = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               run_c = 1'b1;
               if (cnt_q == CW'(MULDIV_STEPS - 1)) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            fix_c   = !flush;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand magnitudes for signed ops, raw values otherwise.
   always_comb begin
      is_signed_c = (op_c == OP_MULT) || (op_c == OP_DIV);
      sa_c        = is_signed_c && a[XLEN-1];
      sb_c        = is_signed_c && b[XLEN-1];
      mag_a_c     = sa_c ? (XLEN'(0) - a) : a;
      mag_b_c     = sb_c ? (XLEN'(0) - b) : b;
   end

   // Divide shifts the next dividend bit into the remainder; multiply adds
   // the multiplicand only when the current multiplier LSB is set.
   always_comb begin
      step_partial_c = is_div_q ? {acc_q[XLEN-1:0], mq_q[XLEN-1]} : acc_q;
      step_operand_c = (is_div_q || mq_q[0]) ? {1'b0, mcand_q} : PW'(0);
   end

   muldiv_step #(.W(PW)) u_step (
      .mode    (is_div_q),
      .partial (step_partial_c),
      .operand (step_operand_c),
      .next_c  (step_next_c),
      .q_bit_c (step_q_bit_c)
   );

   // Final sign correction; divide-by-zero forces an all-ones quotient.
   always_comb begin
      prod_c     = {acc_q[XLEN-1:0], mq_q};
      prod_fix_c = neg_lo_q ? (DW'(0) - prod_c) : prod_c;
      quot_fix_c = neg_lo_q ? (XLEN'(0) - mq_q) : mq_q;
      if (div_zero_q) quot_fix_c = '1;
      rem_fix_c  = neg_hi_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         busy       <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         mq_q       <= '0;
         mcand_q    <= '0;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         div_zero_q <= 1'b0;
         hi         <= '0;
         lo         <= '0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != ST_IDLE);
         if (load_c) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            is_div_q   <= op[1];
            mq_q       <= op[1] ? mag_a_c : mag_b_c;
            mcand_q    <= op[1] ? mag_b_c : mag_a_c;
            neg_lo_q   <= sa_c ^ sb_c;
            neg_hi_q   <= sa_c;
            div_zero_q <= op[1] && (b == '0);
         end
         if (run_c) begin
            cnt_q <= cnt_q + CW'(1);
            if (is_div_q) begin
               acc_q <= step_next_c;
               mq_q  <= {mq_q[XLEN-2:0], step_q_bit_c};
            end else begin
               acc_q <= {1'b0, step_next_c[PW-1:1]};
               mq_q  <= {step_next_c[0], mq_q[XLEN-1:1]};
            end
         end
         if (fix_c) begin
            if (is_div_q) begin
               hi <= rem_fix_c;
               lo <= quot_fix_c;
            end else begin
               hi <= prod_fix_c[DW-1:XLEN];
               lo <= prod_fix_c[XLEN-1:0];
            end
         end
         if (mthi_c) hi <= a;
         if (mtlo_c) lo <= a;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, busy window, MTHI/MTLO, flush, reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int n;

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
      int c;
      issue(o, x, y);
      wait_idle(c);
      chk({tag, " busy_cycles"}, 32'(c), 32'd33);
      chk({tag, " hi"}, hi, eh);
      chk({tag, " lo"}, lo, el);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset hi", hi, 32'h0);
      chk("reset lo", lo, 32'h0);

      run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_zero", 3'b011, 32'h0000_0064, 32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
      run_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("div_zero",  3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // MTHI then MTLO on consecutive cycles
      op = 3'b100; a = 32'h1234_5678; start = 1'b1;
      @(negedge clk);
      chk("mthi busy", 32'(busy), 32'd0);
      chk("mthi hi", hi, 32'h1234_5678);
      op = 3'b101; a = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo busy", 32'(busy), 32'd0);
      chk("mtlo lo", lo, 32'h9ABC_DEF0);
      chk("mtlo hi kept", hi, 32'h1234_5678);

      // second start while busy is dropped
      issue(3'b001, 32'd5, 32'd5);
      op = 3'b001; a = 32'd7; b = 32'd7; start = 1'b1;
      repeat (5) @(negedge clk);
      start = 1'b0;
      chk("midrun hi", hi, 32'h1234_5678);
      chk("midrun lo", lo, 32'h9ABC_DEF0);
      wait_idle(n);
      chk("ignored busy_cycles", 32'(n), 32'd28);
      chk("ignored hi", hi, 32'd0);
      chk("ignored lo", lo, 32'd25);
      @(negedge clk);
      chk("ignored no_queue", 32'(busy), 32'd0);

      // flush at RUN cycle 10, then immediate restart
      issue(3'b000, 32'd3, 32'd4);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy", 32'(busy), 32'd0);
      chk("flush hi", hi, 32'd0);
      chk("flush lo", lo, 32'd25);
      run_op("after_flush", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

      // reset mid-divide clears HI/LO
      issue(3'b100, 32'hDEAD_BEEF, 32'd0);
      chk("mthi2 hi", hi, 32'hDEAD_BEEF);
      issue(3'b011, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

      // start together with flush in IDLE does nothing
      op = 3'b101; a = 32'h55; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("idle_flush mtlo", lo, 32'd14);
      op = 3'b000; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("idle_flush mult busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("idle_flush later busy", 32'(busy), 32'd0);
      chk("idle_flush hi", hi, 32'd2);

      // no-op code
      issue(3'b110, 32'hFFFF_FFFF, 32'd1);
      chk("nop busy", 32'(busy), 32'd0);
      chk("nop hi", hi, 32'd2);
      chk("nop lo", lo, 32'd14);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
